// File: rtl/axi_wmst_pkg.sv
// Shared types and constants for the AXI4 write-master controller.
// Beats are always 64 bytes, so address/size arithmetic works in beat units.
package axi_wmst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_DONE = 3'd4
  } wmst_state_e;

  localparam logic [1:0] BURST_INCR     = 2'b01;
  localparam logic [2:0] SIZE_64B       = 3'b110;
  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam int         BOUNDARY_BYTES = 4096;
  localparam int         BEAT_SHIFT     = 6;

endpackage

// File: rtl/axi_wmst_burst_calc.sv
// Burst length for the next AW: the smallest of the beats still owed, the
// configured burst cap, and the beats left before the next 4 KB page.
module axi_wmst_burst_calc
  import axi_wmst_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int MAX_BEATS = 64
) (
  input  logic [5:0]        page_off,
  input  logic [ADDR_W-1:0] beats_left,
  output logic [8:0]        beats
);

  localparam logic [8:0] PAGE_BEATS = 9'(BOUNDARY_BYTES >> BEAT_SHIFT);
  localparam logic [8:0] CAP_BEATS  = 9'(MAX_BEATS);

  logic [8:0] room;
  logic [8:0] lim;

  always_comb begin
    // page_off is cur_addr[11:6]; room is therefore always 1..64
    room  = PAGE_BEATS - {3'b000, page_off};
    lim   = (room < CAP_BEATS) ? room : CAP_BEATS;
    beats = (beats_left < ADDR_W'(lim)) ? beats_left[8:0] : lim;
  end

endmodule

// File: rtl/axi_wmst_ctrl.sv
// AXI4 write master: splits a byte-addressed request into 4 KB-safe INCR
// bursts, streams W data straight from the flattener, one burst in flight.
module axi_wmst_ctrl
  import axi_wmst_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int ADDR_W    = 64,
  parameter int MAX_BEATS = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [ADDR_W-1:0]   xfer_size,
  output logic                done,
  output logic                busy,
  output logic                err,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [2:0]          dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // The controller never drops awvalid before awready; W valid/ready are
  // forwarded between the stream and the W channel only while in ST_W.

  wmst_state_e state, state_nxt;

  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] beats_left;
  logic [7:0]        awlen_q;
  logic [7:0]        beat_cnt;
  logic              err_q;

  logic [ADDR_W-1:0] burst_beats;
  logic [ADDR_W-1:0] ld_addr;
  logic [ADDR_W-1:0] ld_left;
  logic [8:0]        calc_beats;
  logic [8:0]        calc_len;
  logic              load;
  logic              w_hs;
  logic              wlast_now;
  logic              unused_ok;

  assign burst_beats = ADDR_W'(awlen_q) + ADDR_W'(1);
  assign unused_ok   = ^{addr[5:0], xfer_size[5:0], calc_len[8]};

  // Address/count the next burst will use: the new request from IDLE, or
  // the post-burst values from B. Feeding the calc from here lets m_awlen
  // be registered on the same edge that enters AW.
  always_comb begin
    if (state == ST_IDLE) begin
      ld_addr = {addr[ADDR_W-1:BEAT_SHIFT], 6'b0};
      ld_left = {6'b0, xfer_size[ADDR_W-1:BEAT_SHIFT]};
    end else begin
      ld_addr = cur_addr + (burst_beats << BEAT_SHIFT);
      ld_left = beats_left - burst_beats;
    end
  end

  axi_wmst_burst_calc #(
    .ADDR_W    (ADDR_W),
    .MAX_BEATS (MAX_BEATS)
  ) u_burst_calc (
    .page_off   (ld_addr[11:6]),
    .beats_left (ld_left),
    .beats      (calc_beats)
  );

  assign calc_len  = calc_beats - 9'd1;
  assign load      = ((state == ST_IDLE) && req) || ((state == ST_B) && m_bvalid);
  assign w_hs      = (state == ST_W) && s_tvalid && m_wready;
  assign wlast_now = (beat_cnt == awlen_q);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req)                    state_nxt = (ld_left == '0) ? ST_DONE : ST_AW;
      ST_AW:   if (m_awready)              state_nxt = ST_W;
      ST_W:    if (w_hs && wlast_now)      state_nxt = ST_B;
      ST_B:    if (m_bvalid)               state_nxt = (ld_left == '0) ? ST_DONE : ST_AW;
      ST_DONE:                             state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur_addr   <= '0;
      beats_left <= '0;
      awlen_q    <= '0;
      beat_cnt   <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        cur_addr   <= ld_addr;
        beats_left <= ld_left;
        if (ld_left != '0) awlen_q <= calc_len[7:0];
      end
      if ((state == ST_IDLE) && req)
        err_q <= 1'b0;
      else if ((state == ST_B) && m_bvalid && (m_bresp != RESP_OKAY))
        err_q <= 1'b1;
      if (state == ST_AW)
        beat_cnt <= '0;
      else if (w_hs)
        beat_cnt <= beat_cnt + 8'd1;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign err       = err_q;
  assign dbg_state = state;

  assign m_awaddr  = cur_addr;
  assign m_awlen   = awlen_q;
  assign m_awsize  = SIZE_64B;
  assign m_awburst = BURST_INCR;
  assign m_awvalid = (state == ST_AW);

  assign m_wvalid  = (state == ST_W) && s_tvalid;
  assign s_tready  = (state == ST_W) && m_wready;
  assign m_wdata   = (state == ST_W) ? s_tdata : '0;
  assign m_wstrb   = (state == ST_W) ? '1 : '0;
  assign m_wlast   = (state == ST_W) && wlast_now;
  assign m_bready  = (state == ST_B);

endmodule

// File: tb/tb_axi_wmst_ctrl.sv
// Directed bench for axi_wmst_ctrl: memory-side responder, flattener-side
// source, W-data scoreboard, and per-transfer AW/W/B/done logs.
module tb_axi_wmst_ctrl;

  localparam int DATA_W    = 512;
  localparam int ADDR_W    = 64;
  localparam int MAX_BEATS = 64;

  logic                clk;
  logic                rst;
  logic                req;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   xfer_size;
  logic                done;
  logic                busy;
  logic                err;
  logic [DATA_W-1:0]   s_tdata;
  logic                s_tvalid;
  logic                s_tready;
  logic [ADDR_W-1:0]   m_awaddr;
  logic [7:0]          m_awlen;
  logic [2:0]          m_awsize;
  logic [1:0]          m_awburst;
  logic                m_awvalid;
  logic                m_awready;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_wlast;
  logic                m_wvalid;
  logic                m_wready;
  logic [1:0]          m_bresp;
  logic                m_bvalid;
  logic                m_bready;
  logic [2:0]          dbg_state;

  axi_wmst_ctrl #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .addr      (addr),
    .xfer_size (xfer_size),
    .done      (done),
    .busy      (busy),
    .err       (err),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .m_awaddr  (m_awaddr),
    .m_awlen   (m_awlen),
    .m_awsize  (m_awsize),
    .m_awburst (m_awburst),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wlast   (m_wlast),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_bresp   (m_bresp),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] src_q[$];
  logic [ADDR_W-1:0] aw_addr_q[$];
  logic [7:0]        aw_len_q[$];
  int                aw_cyc_q[$];
  logic              w_last_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int c0 = 0;
  int w_count = 0;
  int pend_b = 0;
  int b_count = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int viol = 0;
  int slverr_idx = -1;
  bit rand_mode = 1'b0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor (samples on falling edge) ----------------
  always @(negedge clk) begin
    if (rst) begin
      pend_b = 0;
    end else begin
      if (m_awvalid && m_awready) begin
        aw_addr_q.push_back(m_awaddr);
        aw_len_q.push_back(m_awlen);
        aw_cyc_q.push_back(cyc - c0);
      end
      if (m_wvalid && m_wready) begin
        w_count++;
        w_last_q.push_back(m_wlast);
        check("w_strb", m_wstrb, {(DATA_W/8){1'b1}});
        check("w_beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("w_data", m_wdata, exp_q.pop_front());
        if (m_wlast) pend_b++;
      end
      if (s_tvalid && s_tready && src_q.size() > 0) void'(src_q.pop_front());
      if (m_bvalid && m_bready) begin
        pend_b--;
        b_count++;
      end
      if (done) begin
        if (done_cnt == 0) done_cyc = cyc - c0;
        done_cnt++;
      end
      if ((m_wvalid || s_tready) && (!busy || m_awvalid || m_bready || done)) viol++;
    end
  end

  // ---------------- memory + flattener drivers ----------------
  initial begin
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    m_bresp   = 2'b00;
    s_tvalid  = 1'b0;
    s_tdata   = '0;
    forever begin
      @(posedge clk);
      #1;
      m_awready = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      m_wready  = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      m_bvalid  = (pend_b > 0) && (rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1);
      m_bresp   = (m_bvalid && (b_count == slverr_idx)) ? 2'b10 : 2'b00;
      if (src_q.size() > 0) begin
        s_tvalid = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        s_tdata  = src_q[0];
      end else begin
        s_tvalid = 1'b0;
        s_tdata  = '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_src(input int n);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < DATA_W / 32; k++) w[k*32 +: 32] = $urandom();
      src_q.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic clear_logs();
    aw_addr_q.delete();
    aw_len_q.delete();
    aw_cyc_q.delete();
    w_last_q.delete();
    w_count  = 0;
    b_count  = 0;
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic start_xfer(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] s);
    @(posedge clk);
    #1;
    addr      = a;
    xfer_size = s;
    req       = 1'b1;
    c0        = cyc;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_cnt == 0; k++) begin
      @(negedge clk);
      #1;
    end
    check("done_seen", done_cnt > 0, 1);
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic check_cleared(input string pfx);
    check({pfx, "_done"},    done, 0);
    check({pfx, "_busy"},    busy, 0);
    check({pfx, "_err"},     err, 0);
    check({pfx, "_tready"},  s_tready, 0);
    check({pfx, "_awvalid"}, m_awvalid, 0);
    check({pfx, "_awaddr"},  m_awaddr, 0);
    check({pfx, "_awlen"},   m_awlen, 0);
    check({pfx, "_wvalid"},  m_wvalid, 0);
    check({pfx, "_wlast"},   m_wlast, 0);
    check({pfx, "_wdata"},   m_wdata, 0);
    check({pfx, "_wstrb"},   m_wstrb, 0);
    check({pfx, "_bready"},  m_bready, 0);
    check({pfx, "_awsize"},  m_awsize, 3'b110);
    check({pfx, "_awburst"}, m_awburst, 2'b01);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst       = 1'b1;
    req       = 1'b0;
    addr      = '0;
    xfer_size = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // single beat, everything ready: AW@1, W@2, B@3, done@4
    clear_logs();
    load_src(1);
    start_xfer(64'h1000, 64'd64);
    wait_done(50);
    check("t1_aw_count", aw_addr_q.size(), 1);
    check("t1_aw_addr", aw_addr_q[0], 64'h1000);
    check("t1_aw_len", aw_len_q[0], 0);
    check("t1_aw_cyc", aw_cyc_q[0], 1);
    check("t1_wlast", w_last_q[0], 1);
    check("t1_b_count", b_count, 1);
    check("t1_done_cyc", done_cyc, 4);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_err", err, 0);

    // zero size: done in cycle 1, no AXI activity
    clear_logs();
    start_xfer(64'h4000, 64'd0);
    wait_done(20);
    check("t0_done_cyc", done_cyc, 1);
    check("t0_aw_count", aw_addr_q.size(), 0);
    check("t0_w_count", w_count, 0);

    // 4 KB crossing: 1 beat at 0xFC0 then 3 beats at 0x1000
    clear_logs();
    load_src(4);
    start_xfer(64'h0FC0, 64'd256);
    wait_done(100);
    check("t2_aw_count", aw_addr_q.size(), 2);
    check("t2_aw0_addr", aw_addr_q[0], 64'h0FC0);
    check("t2_aw0_len", aw_len_q[0], 0);
    check("t2_aw1_addr", aw_addr_q[1], 64'h1000);
    check("t2_aw1_len", aw_len_q[1], 2);
    check("t2_aw1_cyc", aw_cyc_q[1], 4);
    check("t2_wlast_b0", w_last_q[0], 1);
    check("t2_wlast_b1", w_last_q[1], 0);
    check("t2_wlast_b2", w_last_q[2], 0);
    check("t2_wlast_b3", w_last_q[3], 1);
    check("t2_done_cyc", done_cyc, 9);
    check("t2_done_cnt", done_cnt, 1);

    // 8 KB at 0: two full bursts, bubble-free
    clear_logs();
    load_src(128);
    start_xfer(64'h0, 64'd8192);
    wait_done(400);
    check("t3_aw_count", aw_addr_q.size(), 2);
    check("t3_aw0_addr", aw_addr_q[0], 64'h0);
    check("t3_aw0_len", aw_len_q[0], 63);
    check("t3_aw1_addr", aw_addr_q[1], 64'h1000);
    check("t3_aw1_len", aw_len_q[1], 63);
    check("t3_w_count", w_count, 128);
    check("t3_wlast_63", w_last_q[63], 1);
    check("t3_wlast_64", w_last_q[64], 0);
    check("t3_done_cyc", done_cyc, 133);
    check("t3_exp_empty", exp_q.size(), 0);

    // random gaps on both sides: 4 beats to the page edge, then 16
    clear_logs();
    rand_mode = 1'b1;
    load_src(20);
    start_xfer(64'h2F00, 64'd1280);
    wait_done(3000);
    rand_mode = 1'b0;
    check("t4_aw_count", aw_addr_q.size(), 2);
    check("t4_aw0_addr", aw_addr_q[0], 64'h2F00);
    check("t4_aw0_len", aw_len_q[0], 3);
    check("t4_aw1_addr", aw_addr_q[1], 64'h3000);
    check("t4_aw1_len", aw_len_q[1], 15);
    check("t4_w_count", w_count, 20);
    check("t4_exp_empty", exp_q.size(), 0);
    check("t4_wvalid_outside_w", viol, 0);
    check("t4_done_cnt", done_cnt, 1);

    // SLVERR on the second burst makes err sticky
    clear_logs();
    slverr_idx = 1;
    load_src(4);
    start_xfer(64'h0FC0, 64'd256);
    wait_done(100);
    slverr_idx = -1;
    check("t5_err_set", err, 1);
    check("t5_done_cnt", done_cnt, 1);
    repeat (3) @(negedge clk);
    check("t5_err_sticky", err, 1);

    // next request clears err; low address/size bits are ignored
    clear_logs();
    load_src(1);
    start_xfer(64'h2007, 64'h7F);
    @(negedge clk);
    check("t6_err_cleared", err, 0);
    wait_done(50);
    check("t6_aw_addr", aw_addr_q[0], 64'h2000);
    check("t6_aw_len", aw_len_q[0], 0);
    check("t6_done_cnt", done_cnt, 1);
    check("t6_err_end", err, 0);

    // reset during the third W beat of eight
    clear_logs();
    load_src(8);
    start_xfer(64'h0, 64'd512);
    for (int k = 0; k < 50 && w_count < 2; k++) begin
      @(negedge clk);
      #1;
    end
    check("t7_reached_beat3", w_count, 2);
    rst = 1'b1;
    #1;
    check_cleared("t7_async");
    @(posedge clk);
    #1;
    check_cleared("t7_edge");
    src_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t7_no_done", done_cnt, 0);
    clear_logs();
    load_src(1);
    start_xfer(64'h1000, 64'd64);
    wait_done(50);
    check("t7_after_done_cyc", done_cyc, 4);
    check("t7_after_aw_addr", aw_addr_q[0], 64'h1000);
    check("t7_after_w_count", w_count, 1);

    // req while busy is ignored
    clear_logs();
    load_src(4);
    start_xfer(64'h0, 64'd256);
    @(posedge clk);
    #1;
    addr      = 64'h8000;
    xfer_size = 64'd64;
    req       = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    wait_done(100);
    repeat (10) @(negedge clk);
    check("t8_done_cnt", done_cnt, 1);
    check("t8_aw_count", aw_addr_q.size(), 1);
    check("t8_aw_addr", aw_addr_q[0], 64'h0);
    check("t8_aw_len", aw_len_q[0], 3);
    check("t8_busy_end", busy, 0);
    check("t8_wvalid_outside_w", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
